// File: rtl/wb_commit_buffer.sv
// Multi-channel writeback commit buffer: round-robin intake, load extraction at
// enqueue, DEPTH-entry FIFO draining one regfile write per cycle, forwarding lookup.
module wb_commit_buffer #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned RIDX   = 5
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_CH-1:0]                     ch_valid,
    output logic [NUM_CH-1:0]                     ch_ready,
    input  logic [NUM_CH*RIDX-1:0]                ch_rd,
    input  logic [NUM_CH*XLEN-1:0]                ch_data,
    input  logic [NUM_CH*$clog2(XLEN/8)-1:0]      ch_addr_lo,
    input  logic [NUM_CH*3-1:0]                   ch_mode,
    input  logic                                  rf_ready,
    output logic                                  rf_we,
    output logic [RIDX-1:0]                       rf_rd,
    output logic [XLEN-1:0]                       rf_wdata,
    input  logic [RIDX-1:0]                       fwd_rs,
    output logic                                  fwd_hit,
    output logic [XLEN-1:0]                       fwd_data,
    output logic [$clog2(DEPTH):0]                count
);

    localparam int unsigned LW  = $clog2(XLEN / 8);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned RRW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        M_PASS  = 3'b000,
        M_LB    = 3'b001,
        M_LH    = 3'b010,
        M_LW    = 3'b011,
        M_LBU   = 3'b100,
        M_LHU   = 3'b101,
        M_LWU   = 3'b110,
        M_PASS2 = 3'b111
    } mode_e;

    // Misaligned halfword/word accesses simply drop the low lane bits.
    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] data,
                                                input logic [LW-1:0]   lo,
                                                input mode_e           mode);
        logic [LW-1:0]   h_lo;
        logic [LW-1:0]   w_lo;
        logic [7:0]      b;
        logic [15:0]     h;
        logic [31:0]     w;
        logic [XLEN-1:0] res;
        h_lo = lo & ~LW'(1);
        w_lo = lo & ~LW'(3);
        b    = data[{lo, 3'b000} +: 8];
        h    = data[{h_lo, 3'b000} +: 16];
        w    = data[{w_lo, 3'b000} +: 32];
        case (mode)
            M_LB:    res = XLEN'($signed(b));
            M_LH:    res = XLEN'($signed(h));
            M_LW:    res = XLEN'($signed(w));
            M_LBU:   res = XLEN'(b);
            M_LHU:   res = XLEN'(h);
            M_LWU:   res = XLEN'(w);
            default: res = data;
        endcase
        return res;
    endfunction

    logic [RIDX-1:0] ent_rd   [DEPTH];
    logic [XLEN-1:0] ent_data [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [RRW-1:0]  rr_ptr;

    logic [RRW-1:0]  gnt;
    logic            gnt_any;
    logic [RRW:0]    cand;
    logic            deq;
    logic            space;
    logic            xfer;
    logic            enq;
    logic [RIDX-1:0] sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [PW-1:0]   fidx;

    // First valid channel at or after rr_ptr, wrapping at NUM_CH.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, rr_ptr} + (RRW + 1)'(i);
            if (cand >= (RRW + 1)'(NUM_CH)) cand = cand - (RRW + 1)'(NUM_CH);
            if (!gnt_any && ch_valid[cand[RRW-1:0]]) begin
                gnt_any = 1'b1;
                gnt     = cand[RRW-1:0];
            end
        end
    end

    always_comb begin
        deq      = (count != '0) & rf_ready & ~rst;
        space    = (count < CW'(DEPTH)) | deq;
        xfer     = gnt_any & space & ~rst;
        ch_ready = '0;
        if (xfer) ch_ready[gnt] = 1'b1;
        sel_rd   = ch_rd[gnt*RIDX +: RIDX];
        sel_data = extract(ch_data[gnt*XLEN +: XLEN],
                           ch_addr_lo[gnt*LW +: LW],
                           mode_e'(ch_mode[gnt*3 +: 3]));
        enq      = xfer & (sel_rd != '0);
        rf_we    = deq;
        rf_rd    = ent_rd[rd_ptr];
        rf_wdata = ent_data[rd_ptr];
    end

    // Oldest-to-newest walk; a later match overrides, so the youngest entry wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fidx     = '0;
        if (!rst && fwd_rs != '0) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fidx = rd_ptr + PW'(i);
                if (CW'(i) < count && ent_rd[fidx] == fwd_rs) begin
                    fwd_hit  = 1'b1;
                    fwd_data = ent_data[fidx];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            rr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_rd[PW'(i)]   <= '0;
                ent_data[PW'(i)] <= '0;
            end
        end else begin
            if (enq) begin
                ent_rd[wr_ptr]   <= sel_rd;
                ent_data[wr_ptr] <= sel_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            if (enq && !deq)      count <= count + 1'b1;
            else if (deq && !enq) count <= count - 1'b1;
            if (xfer) rr_ptr <= (gnt == RRW'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_commit_buffer.sv
// Scoreboard bench for wb_commit_buffer: stimulus pushes expected regfile writes,
// a negedge monitor pops and compares each rf_we cycle.
module tb_wb_commit_buffer;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NUM_CH = 2;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned RIDX   = 5;

    logic        clk;
    logic        rst;
    logic [1:0]  ch_valid;
    logic [1:0]  ch_ready;
    logic [9:0]  ch_rd;
    logic [63:0] ch_data;
    logic [3:0]  ch_addr_lo;
    logic [5:0]  ch_mode;
    logic        rf_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [4:0]  fwd_rs;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [2:0]  count;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    logic [4:0]  exp_rd[$];
    logic [31:0] exp_data[$];

    // Extraction vectors on raw word 0x80FF1234 (bytes 34,12,FF,80).
    logic [1:0]  lo_t   [13] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2};
    logic [2:0]  mode_t [13] = '{3'b001, 3'b100, 3'b010, 3'b001, 3'b001, 3'b101, 3'b101, 3'b010, 3'b011, 3'b110, 3'b000, 3'b111, 3'b100};
    logic [31:0] exp_t  [13] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00000012, 32'hFFFFFFFF,
                                 32'h00001234, 32'h000080FF, 32'h00001234, 32'h80FF1234, 32'h80FF1234,
                                 32'h80FF1234, 32'h80FF1234, 32'h000000FF};

    wb_commit_buffer #(
        .XLEN   (XLEN),
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH),
        .RIDX   (RIDX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_valid   (ch_valid),
        .ch_ready   (ch_ready),
        .ch_rd      (ch_rd),
        .ch_data    (ch_data),
        .ch_addr_lo (ch_addr_lo),
        .ch_mode    (ch_mode),
        .rf_ready   (rf_ready),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wdata   (rf_wdata),
        .fwd_rs     (fwd_rs),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
        .count      (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Present one result on channel ch, wait (bounded) for the grant, transfer it.
    task automatic send(input int ch, input logic [4:0] rd, input logic [31:0] data,
                        input logic [1:0] lo, input logic [2:0] mode,
                        input logic [31:0] expd, input bit push, output int unsigned waited);
        waited = 0;
        ch_rd[ch*5 +: 5]       = rd;
        ch_data[ch*32 +: 32]   = data;
        ch_addr_lo[ch*2 +: 2]  = lo;
        ch_mode[ch*3 +: 3]     = mode;
        ch_valid[ch]           = 1'b1;
        #1;
        while (ch_ready[ch] !== 1'b1 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (ch_ready[ch] !== 1'b1) begin
            chk("send_ready", 64'(ch_ready[ch]), 64'd1);
            ch_valid[ch] = 1'b0;
        end else begin
            if (push && rd != 5'd0) begin
                exp_rd.push_back(rd);
                exp_data.push_back(expd);
            end
            @(posedge clk);
            #1;
            ch_valid[ch] = 1'b0;
        end
    endtask

    // Monitor: every regfile write must match the oldest outstanding expectation.
    initial begin
        logic [4:0]  r;
        logic [31:0] d;
        forever begin
            @(negedge clk);
            if (rf_we === 1'b1) begin
                if (exp_rd.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write at %0t",
                             rf_rd, rf_wdata, $time);
                end else begin
                    r = exp_rd.pop_front();
                    d = exp_data.pop_front();
                    chk("wb_rd", 64'(rf_rd), 64'(r));
                    chk("wb_data", 64'(rf_wdata), 64'(d));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned w;
        rst        = 1'b1;
        ch_valid   = 2'b11;
        ch_rd      = '0;
        ch_data    = '0;
        ch_addr_lo = '0;
        ch_mode    = '0;
        rf_ready   = 1'b1;
        fwd_rs     = 5'd5;
        #3;
        chk("rst_ready", 64'(ch_ready), 64'd0);
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_hit", 64'(fwd_hit), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        ch_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // Extraction modes, drained one per cycle.
        for (int i = 0; i < 13; i++) begin
            send(0, 5'(5 + i), 32'h80FF1234, lo_t[i], mode_t[i], exp_t[i], 1'b1, w);
            chk("grant_latency", 64'(w), 64'd0);
            chk("count_le1_t1", 64'(count <= 3'd1), 64'd1);
        end
        step();
        step();
        chk("t1_drained", 64'(count), 64'd0);

        // Round-robin alternation from reset.
        do_reset();
        ch_rd        = {5'd2, 5'd1};
        ch_data      = {32'h20000002, 32'h10000001};
        ch_addr_lo   = '0;
        ch_mode      = '0;
        ch_valid     = 2'b11;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_grant", 64'(ch_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
            chk("count_le1", 64'(count <= 3'd1), 64'd1);
            exp_rd.push_back((k % 2 == 0) ? 5'd1 : 5'd2);
            exp_data.push_back((k % 2 == 0) ? 32'h10000001 : 32'h20000002);
            @(posedge clk);
            #1;
        end
        ch_valid = '0;
        step();
        step();
        chk("t2_drained", 64'(count), 64'd0);

        // Fill to DEPTH under backpressure, then accept the 5th on the first drain cycle.
        rf_ready    = 1'b0;
        ch_valid[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ch_rd[4:0]    = 5'(10 + k);
            ch_data[31:0] = 32'(32'h100 + k);
            #1;
            chk("fill_ready", 64'(ch_ready), 64'd1);
            exp_rd.push_back(5'(10 + k));
            exp_data.push_back(32'(32'h100 + k));
            @(posedge clk);
            #1;
        end
        ch_rd[4:0]    = 5'd14;
        ch_data[31:0] = 32'h104;
        #1;
        chk("full_count", 64'(count), 64'd4);
        chk("full_block", 64'(ch_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("full_block2", 64'(ch_ready), 64'd0);
        rf_ready = 1'b1;
        #1;
        chk("drain_accept", 64'(ch_ready), 64'd1);
        chk("drain_we", 64'(rf_we), 64'd1);
        exp_rd.push_back(5'd14);
        exp_data.push_back(32'h104);
        @(posedge clk);
        #1;
        ch_valid = '0;
        chk("enq_deq_count", 64'(count), 64'd4);
        repeat (5) step();
        chk("t3_drained", 64'(count), 64'd0);

        // Forwarding: youngest match wins, rd 0 never hits, popping entry still hits.
        rf_ready = 1'b0;
        send(0, 5'd7, 32'h11, 2'd0, 3'b000, 32'h11, 1'b1, w);
        send(0, 5'd7, 32'h22, 2'd0, 3'b000, 32'h22, 1'b1, w);
        fwd_rs = 5'd7;
        #1;
        chk("fwd_hit_young", 64'(fwd_hit), 64'd1);
        chk("fwd_data_young", 64'(fwd_data), 64'h22);
        fwd_rs = 5'd0;
        #1;
        chk("fwd_r0_hit", 64'(fwd_hit), 64'd0);
        chk("fwd_r0_data", 64'(fwd_data), 64'd0);
        step();
        fwd_rs = 5'd3;
        #1;
        chk("fwd_miss", 64'(fwd_hit), 64'd0);
        step();
        fwd_rs   = 5'd7;
        rf_ready = 1'b1;
        #1;
        chk("fwd_popping_hit", 64'(fwd_hit), 64'd1);
        chk("fwd_popping_data", 64'(fwd_data), 64'h22);
        step();
        chk("fwd_after_pop_hit", 64'(fwd_hit), 64'd1);
        chk("fwd_after_pop_data", 64'(fwd_data), 64'h22);
        chk("fwd_after_pop_count", 64'(count), 64'd1);
        step();
        chk("fwd_empty_hit", 64'(fwd_hit), 64'd0);
        chk("fwd_empty_count", 64'(count), 64'd0);

        // rd==0 is accepted without enqueue and still advances the rr pointer.
        do_reset();
        rf_ready      = 1'b1;
        ch_rd[4:0]    = 5'd0;
        ch_data[31:0] = 32'hDEAD;
        ch_mode       = '0;
        ch_addr_lo    = '0;
        ch_valid      = 2'b01;
        #1;
        chk("r0_ready", 64'(ch_ready), 64'd1);
        step();
        ch_valid = '0;
        chk("r0_count", 64'(count), 64'd0);
        chk("r0_we", 64'(rf_we), 64'd0);
        ch_rd         = {5'd9, 5'd3};
        ch_data       = {32'h99, 32'h33};
        ch_valid      = 2'b11;
        #1;
        chk("r0_rr_adv", 64'(ch_ready), 64'd2);
        exp_rd.push_back(5'd9);
        exp_data.push_back(32'h99);
        step();
        ch_valid = '0;
        step();
        step();
        chk("t5_drained", 64'(count), 64'd0);

        // Asynchronous reset mid-cycle discards pending entries.
        rf_ready = 1'b0;
        send(0, 5'd4, 32'h44, 2'd0, 3'b000, 32'h44, 1'b0, w);
        send(0, 5'd6, 32'h66, 2'd0, 3'b000, 32'h66, 1'b0, w);
        send(0, 5'd8, 32'h88, 2'd0, 3'b000, 32'h88, 1'b0, w);
        chk("pre_rst_count", 64'(count), 64'd3);
        fwd_rs     = 5'd4;
        rf_ready   = 1'b1;
        ch_rd[4:0] = 5'd12;
        ch_valid   = 2'b01;
        #1;
        chk("pre_rst_we", 64'(rf_we), 64'd1);
        chk("pre_rst_ready", 64'(ch_ready), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_we", 64'(rf_we), 64'd0);
        chk("async_rst_ready", 64'(ch_ready), 64'd0);
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_hit", 64'(fwd_hit), 64'd0);
        ch_valid = '0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("post_rst_count", 64'(count), 64'd0);
        repeat (4) step();
        chk("post_rst_idle", 64'(count), 64'd0);
        chk("post_rst_fwd", 64'(fwd_hit), 64'd0);

        chk("sb_empty", 64'(exp_rd.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
